traffic_light_rr: RTL and testbench

Parametrised, timed, round-robin controller for one four-way light in a Verilog Town level. It replaces the purely combinational per-light decision with a registered state machine that has minimum and maximum green, an all-stop clearance interval and fair rotation between the approaches. Demand comes from the light's own 8 sensors, optionally extended by level-placed general sensors through per-direction masks. It drives the same four 3-bit light codes as every other light in the level.

---
 rtl/traffic_light_rr.sv | 157 +++++++++++++++
 tb/tb_traffic_light_rr.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_rr.sv
// Timed round-robin controller for one four-way light: min/max green, all-stop
// clearance, and fair rotation of the grant between N, S, E and W.
module traffic_light_rr #(
  parameter int          MIN_GREEN    = 4,
  parameter int          MAX_GREEN    = 20,
  parameter int          CLEAR_CYCLES = 2,
  parameter int          TIMER_W      = 8,
  parameter logic [29:0] EXT_N_MASK   = 30'b0,
  parameter logic [29:0] EXT_S_MASK   = 30'b0,
  parameter logic [29:0] EXT_E_MASK   = 30'b0,
  parameter logic [29:0] EXT_W_MASK   = 30'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sensor_light,
  input  logic [29:0] general_sensors,
  output logic [2:0]  outN,
  output logic [2:0]  outS,
  output logic [2:0]  outE,
  output logic [2:0]  outW,
  output logic [29:0] debug_port
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GREEN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  localparam logic [2:0] LIGHT_STOP = 3'b000;
  localparam logic [2:0] LIGHT_GO   = 3'b100;

  localparam logic [TIMER_W-1:0] MIN_LAST   = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_LAST   = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};

  logic [3:0]         demand;
  logic               busy;
  logic [3:0]         grantMask;
  logic [1:0]         state, stateNext;
  logic [1:0]         grant, grantNext;
  logic [1:0]         ptr, ptrNext;
  logic [TIMER_W-1:0] timer, timerNext;

  // First requesting direction, searching from start and wrapping mod 4.
  function automatic logic [1:0] pickNext(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [TIMER_W-1:0] satInc(input logic [TIMER_W-1:0] t,
                                                input logic [TIMER_W-1:0] last);
    return (t >= last) ? last : t + TIMER_W'(1);
  endfunction

  function automatic logic [2:0] lightFor(input logic [1:0] st, input logic [1:0] gr,
                                          input logic [1:0] dir);
    return (st == GREEN && gr == dir) ? LIGHT_GO : LIGHT_STOP;
  endfunction

  // Per-direction demand from own sensors plus masked level sensors.
  always_comb begin
    demand[0] = sensor_light[6] | (|(general_sensors & EXT_N_MASK));
    demand[1] = sensor_light[4] | (|(general_sensors & EXT_S_MASK));
    demand[2] = sensor_light[5] | (|(general_sensors & EXT_E_MASK));
    demand[3] = sensor_light[7] | (|(general_sensors & EXT_W_MASK));
    busy      = |sensor_light[3:0];
    grantMask = 4'b0001 << grant;
  end

  // Next-state, grant, rotation pointer and timer.
  always_comb begin
    stateNext = state;
    grantNext = grant;
    ptrNext   = ptr;
    timerNext = timer;
    case (state)
      IDLE: begin
        if (!busy && (demand != 4'b0000)) begin
          stateNext = GREEN;
          grantNext = pickNext(demand, ptr);
          timerNext = TIMER_ZERO;
        end else begin
          timerNext = TIMER_ZERO;
        end
      end
      GREEN: begin
        // Pre-emption only once max green is reached and someone else is waiting.
        if ((timer >= MIN_LAST) &&
            (!demand[grant] ||
             ((timer >= MAX_LAST) && ((demand & ~grantMask) != 4'b0000)))) begin
          stateNext = CLEAR;
          timerNext = TIMER_ZERO;
        end else begin
          timerNext = satInc(timer, MAX_LAST);
        end
      end
      CLEAR: begin
        if ((timer >= CLEAR_LAST) && !busy) begin
          stateNext = IDLE;
          ptrNext   = grant + 2'd1;
          timerNext = TIMER_ZERO;
        end else begin
          timerNext = satInc(timer, CLEAR_LAST);
        end
      end
      default: begin
        stateNext = IDLE;
        timerNext = TIMER_ZERO;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'd0;
      ptr   <= 2'd0;
      timer <= TIMER_ZERO;
    end else begin
      state <= stateNext;
      grant <= grantNext;
      ptr   <= ptrNext;
      timer <= timerNext;
    end
  end

  // Output registers load the decode of the state being entered, so they
  // always equal the decode of the current state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      outN       <= LIGHT_STOP;
      outS       <= LIGHT_STOP;
      outE       <= LIGHT_STOP;
      outW       <= LIGHT_STOP;
      debug_port <= 30'd0;
    end else begin
      outN       <= lightFor(stateNext, grantNext, 2'd0);
      outS       <= lightFor(stateNext, grantNext, 2'd1);
      outE       <= lightFor(stateNext, grantNext, 2'd2);
      outW       <= lightFor(stateNext, grantNext, 2'd3);
      debug_port <= {24'(timerNext), ptrNext, grantNext, stateNext};
    end
  end

endmodule

// File: tb/tb_traffic_light_rr.sv
// Directed bench for traffic_light_rr with hand-computed light patterns.
module tb_traffic_light_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sensorLight = 8'h00;
  logic [29:0] generalSensors = 30'h0;
  logic [2:0]  outN, outS, outE, outW;
  logic [29:0] debugPort;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] ALL_STOP = 12'h000;
  localparam logic [11:0] GO_N     = 12'h800;
  localparam logic [11:0] GO_S     = 12'h100;
  localparam logic [11:0] GO_E     = 12'h020;
  localparam logic [11:0] GO_W     = 12'h004;

  logic [11:0] goTable [4];
  logic [11:0] lights;

  assign lights = {outN, outS, outE, outW};

  traffic_light_rr #(
    .MIN_GREEN(4), .MAX_GREEN(20), .CLEAR_CYCLES(2), .TIMER_W(8),
    .EXT_N_MASK(30'h0), .EXT_S_MASK(30'h0), .EXT_E_MASK(30'h8), .EXT_W_MASK(30'h0)
  ) dut (
    .clk(clk), .rst(rst), .sensor_light(sensorLight), .general_sensors(generalSensors),
    .outN(outN), .outS(outS), .outE(outE), .outW(outW), .debug_port(debugPort)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle before sampling or driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    sensorLight = 8'h00;
    generalSensors = 30'h0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    goTable[0] = GO_N; goTable[1] = GO_S; goTable[2] = GO_E; goTable[3] = GO_W;

    // Reset with every sensor active
    rst = 1'b1;
    sensorLight = 8'hFF;
    generalSensors = 30'h3FFFFFFF;
    repeat (3) cyc();
    checkVal("rst_lights", 32'(lights), 32'(ALL_STOP));
    checkVal("rst_debug", 32'(debugPort), 32'd0);

    // Release into sole N demand, held for 30 Go cycles
    rst = 1'b0;
    sensorLight = 8'h40;
    generalSensors = 30'h0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      checkVal("sole_go_n", 32'(lights), 32'(GO_N));
    end
    sensorLight = 8'h00;
    cyc();
    checkVal("sole_clear1", 32'(lights), 32'(ALL_STOP));
    checkVal("sole_clear1_st", 32'(debugPort[1:0]), 32'd2);
    cyc();
    checkVal("sole_clear2", 32'(lights), 32'(ALL_STOP));
    checkVal("sole_clear2_st", 32'(debugPort[1:0]), 32'd2);
    cyc();
    checkVal("sole_idle_st", 32'(debugPort[1:0]), 32'd0);
    checkVal("sole_idle_ptr", 32'(debugPort[5:4]), 32'd1);

    // One-cycle E pulse still yields exactly MIN_GREEN Go cycles
    sensorLight = 8'h20;
    cyc();
    sensorLight = 8'h00;
    checkVal("min_go1", 32'(lights), 32'(GO_E));
    for (int i = 0; i < 3; i++) begin
      cyc();
      checkVal("min_go", 32'(lights), 32'(GO_E));
    end
    cyc();
    checkVal("min_clear1", 32'(debugPort[1:0]), 32'd2);
    checkVal("min_clear1_l", 32'(lights), 32'(ALL_STOP));
    cyc();
    checkVal("min_clear2", 32'(debugPort[1:0]), 32'd2);
    cyc();
    checkVal("min_idle", 32'(debugPort[1:0]), 32'd0);
    checkVal("min_idle_ptr", 32'(debugPort[5:4]), 32'd3);

    // Full contention: N, S, E, W, N at 20 Go cycles each, 3 Stop cycles between
    doReset();
    sensorLight = 8'hF0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 20; i++) begin
        cyc();
        checkVal("rr_go", 32'(lights), 32'(goTable[g % 4]));
      end
      if (g < 4) begin
        for (int i = 0; i < 3; i++) begin
          cyc();
          checkVal("rr_gap", 32'(lights), 32'(ALL_STOP));
        end
      end
    end

    // Centre busy stretches CLEAR while W waits
    doReset();
    sensorLight = 8'h40;
    cyc();
    checkVal("busy_go_n1", 32'(lights), 32'(GO_N));
    sensorLight = 8'h80;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checkVal("busy_go_n", 32'(lights), 32'(GO_N));
    end
    sensorLight = 8'h81;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checkVal("busy_clear_l", 32'(lights), 32'(ALL_STOP));
      checkVal("busy_clear_st", 32'(debugPort[1:0]), 32'd2);
    end
    sensorLight = 8'h80;
    cyc();
    checkVal("busy_idle_st", 32'(debugPort[1:0]), 32'd0);
    checkVal("busy_idle_l", 32'(lights), 32'(ALL_STOP));
    cyc();
    checkVal("busy_go_w", 32'(lights), 32'(GO_W));

    // Unmasked general sensor gives no demand; masked bit 3 demands E
    doReset();
    generalSensors = 30'h1;
    cyc();
    checkVal("ext_nomask", 32'(lights), 32'(ALL_STOP));
    generalSensors = 30'h8;
    cyc();
    checkVal("ext_go_e", 32'(lights), 32'(GO_E));
    checkVal("ext_dbg1", 32'(debugPort), 32'h9);
    cyc();
    checkVal("ext_dbg2", 32'(debugPort), 32'h49);
    rst = 1'b1;
    cyc();
    checkVal("midrst_l", 32'(lights), 32'(ALL_STOP));
    checkVal("midrst_dbg", 32'(debugPort), 32'd0);
    rst = 1'b0;
    generalSensors = 30'h0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
